// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the BCD stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  localparam int BCD_W = 4;
  localparam int MOD_DEC = 10;
  localparam int MOD_SEX = 6;
  localparam int DISP_W = 24;
  localparam int OFF_CS_O = 0;
  localparam int OFF_CS_T = 4;
  localparam int OFF_SEC_O = 8;
  localparam int OFF_SEC_T = 12;
  localparam int OFF_MIN_O = 16;
  localparam int OFF_MIN_T = 20;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD digit counting modulo MOD with combinational carry out
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);
  logic [BCD_W-1:0] r_digit;
  logic             w_at_max;
  assign w_at_max = r_digit == BCD_W'(MOD - 1);
  assign carry_out = carry_in & w_at_max;
  assign digit = r_digit;
  always_ff @(posedge clk_in) begin
    if (rst || clr) r_digit <= '0;
    else if (carry_in) r_digit <= w_at_max ? '0 : r_digit + 1'b1;
  end
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: mm:ss.cc BCD stopwatch with start/stop, lap freeze and rollover pulse
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_IS_LEVEL = 1,
  parameter int MINUTE_LIMIT = 60
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              btn_start_stop,
  input  logic              btn_lap_reset,
  output logic [DISP_W-1:0] disp_bcd,
  output logic              running,
  output logic              lap_active,
  output logic              wrap
);
  localparam logic [BCD_W-1:0] MIN_MAX_T = BCD_W'((MINUTE_LIMIT - 1) / 10);
  localparam logic [BCD_W-1:0] MIN_MAX_O = BCD_W'((MINUTE_LIMIT - 1) % 10);
  state_t              r_state;
  state_t              w_state_next;
  logic                r_tick_prev;
  logic                w_tick, w_inc, w_clr, w_lap_toggle;
  logic [BCD_W-1:0]    w_cs_o, w_cs_t, w_sec_o, w_sec_t;
  logic                w_c0, w_c1, w_c2, w_c3;
  logic [BCD_W-1:0]    r_min_t, r_min_o;
  logic                w_min_max;
  logic                r_wrap;
  logic [DISP_W-1:0]   r_lap, r_disp, w_count, w_disp;
  logic                r_lap_active, r_lap_pending;
  assign w_tick = (TICK_IS_LEVEL != 0) ? (tick_in & ~r_tick_prev) : tick_in;
  assign w_inc = w_tick & (r_state == RUN);
  assign w_clr = (r_state == PAUSE) & btn_lap_reset & ~btn_start_stop;
  assign w_lap_toggle = (r_state == RUN) & btn_lap_reset & ~btn_start_stop;
  assign w_state_next = btn_start_stop ? ((r_state == RUN) ? PAUSE : RUN) : (w_clr ? IDLE : r_state);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick_prev <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tick_prev <= tick_in;
    end
  end
  bcd_digit_counter #(.MOD(MOD_DEC)) u_cs_o (.clk_in(clk_in), .rst(rst), .clr(w_clr), .carry_in(w_inc), .digit(w_cs_o), .carry_out(w_c0));
  bcd_digit_counter #(.MOD(MOD_DEC)) u_cs_t (.clk_in(clk_in), .rst(rst), .clr(w_clr), .carry_in(w_c0), .digit(w_cs_t), .carry_out(w_c1));
  bcd_digit_counter #(.MOD(MOD_DEC)) u_sec_o (.clk_in(clk_in), .rst(rst), .clr(w_clr), .carry_in(w_c1), .digit(w_sec_o), .carry_out(w_c2));
  bcd_digit_counter #(.MOD(MOD_SEX)) u_sec_t (.clk_in(clk_in), .rst(rst), .clr(w_clr), .carry_in(w_c2), .digit(w_sec_t), .carry_out(w_c3));
  // minutes compare against the full two-digit limit so non-decade limits wrap correctly
  assign w_min_max = (r_min_t == MIN_MAX_T) && (r_min_o == MIN_MAX_O);
  always_ff @(posedge clk_in) begin
    if (rst || w_clr) begin
      r_min_t <= '0;
      r_min_o <= '0;
    end else if (w_c3) begin
      r_min_o <= (w_min_max || r_min_o == 4'd9) ? '0 : r_min_o + 1'b1;
      r_min_t <= w_min_max ? '0 : ((r_min_o == 4'd9) ? r_min_t + 1'b1 : r_min_t);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) r_wrap <= 1'b0;
    else r_wrap <= w_c3 & w_min_max;
  end
  assign w_count = {r_min_t, r_min_o, w_sec_t, w_sec_o, w_cs_t, w_cs_o};
  // the lap value is the post-increment count, so it is captured one cycle after the press
  always_ff @(posedge clk_in) begin
    if (rst || w_clr) begin
      r_lap <= '0;
      r_lap_active <= 1'b0;
      r_lap_pending <= 1'b0;
    end else begin
      if (w_lap_toggle) r_lap_active <= ~r_lap_active;
      r_lap_pending <= w_lap_toggle & ~r_lap_active;
      if (r_lap_pending) r_lap <= w_count;
    end
  end
  assign w_disp = (r_lap_active && !r_lap_pending) ? r_lap : w_count;
  always_ff @(posedge clk_in) begin
    if (rst) r_disp <= '0;
    else r_disp <= w_disp;
  end
  assign disp_bcd = r_disp;
  assign running = r_state == RUN;
  assign lap_active = r_lap_active;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed checks of the stopwatch in level-tick and pulse-tick configurations
`timescale 1ns/1ps
module tb_stopwatch_bcd;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0, ss = 1'b0, lr = 1'b0;
  logic tick2 = 1'b0, ss2 = 1'b0, lr2 = 1'b0;
  logic [23:0] disp_bcd, disp2;
  logic running, lap_active, wrap, running2, lap2, wrap2;
  int checks = 0;
  int errors = 0;
  always #5 clk_in = ~clk_in;
  stopwatch_bcd #(.TICK_IS_LEVEL(1), .MINUTE_LIMIT(1)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .btn_start_stop(ss), .btn_lap_reset(lr),
    .disp_bcd(disp_bcd), .running(running), .lap_active(lap_active), .wrap(wrap));
  stopwatch_bcd #(.TICK_IS_LEVEL(0), .MINUTE_LIMIT(2)) dut2 (
    .clk_in(clk_in), .rst(rst), .tick_in(tick2), .btn_start_stop(ss2), .btn_lap_reset(lr2),
    .disp_bcd(disp2), .running(running2), .lap_active(lap2), .wrap(wrap2));
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk_in) tick_in = 1'b1;
      @(negedge clk_in) tick_in = 1'b0;
    end
  endtask
  task automatic press_ss();
    @(negedge clk_in) ss = 1'b1;
    @(negedge clk_in) ss = 1'b0;
  endtask
  task automatic press_lr();
    @(negedge clk_in) lr = 1'b1;
    @(negedge clk_in) lr = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in) tick_in = ~tick_in;
    checks++; if (disp_bcd !== 24'h0) begin errors++; $display("FAIL reset_disp got %h exp %h", disp_bcd, 24'h0); end
    checks++; if ({running, lap_active, wrap} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp %b", {running, lap_active, wrap}, 3'b000); end
    checks++; if (disp2 !== 24'h0) begin errors++; $display("FAIL reset_disp2 got %h exp %h", disp2, 24'h0); end
    @(negedge clk_in) begin rst = 1'b0; tick_in = 1'b0; end
    tick_n(1);
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h0) begin errors++; $display("FAIL idle_tick got %h exp %h", disp_bcd, 24'h0); end
  endtask
  task automatic test_basic();
    press_ss();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_start got %b exp %b", running, 1'b1); end
    tick_n(150);
    press_ss();
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h000150) begin errors++; $display("FAIL basic_disp got %h exp %h", disp_bcd, 24'h000150); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL basic_stop got %b exp %b", running, 1'b0); end
    tick_n(5);
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h000150) begin errors++; $display("FAIL basic_paused got %h exp %h", disp_bcd, 24'h000150); end
    press_lr();
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h0) begin errors++; $display("FAIL basic_clear got %h exp %h", disp_bcd, 24'h0); end
  endtask
  task automatic test_lap();
    press_ss();
    tick_n(100);
    press_lr();
    checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL lap_on got %b exp %b", lap_active, 1'b1); end
    tick_n(50);
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h000100) begin errors++; $display("FAIL lap_frozen got %h exp %h", disp_bcd, 24'h000100); end
    press_lr();
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h000150) begin errors++; $display("FAIL lap_release got %h exp %h", disp_bcd, 24'h000150); end
    checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL lap_off got %b exp %b", lap_active, 1'b0); end
    press_ss();
    press_lr();
    wait_cyc(2);
  endtask
  task automatic test_simul();
    press_ss();
    tick_n(3);
    press_lr();
    @(negedge clk_in) begin ss = 1'b1; lr = 1'b1; end
    @(negedge clk_in) begin ss = 1'b0; lr = 1'b0; end
    checks++; if ({running, lap_active} !== 2'b01) begin errors++; $display("FAIL both_btn got %b exp %b", {running, lap_active}, 2'b01); end
    press_ss();
    checks++; if ({running, lap_active} !== 2'b11) begin errors++; $display("FAIL resume_lap got %b exp %b", {running, lap_active}, 2'b11); end
    press_ss();
    press_lr();
    wait_cyc(2);
    checks++; if ({lap_active, disp_bcd} !== 25'h0) begin errors++; $display("FAIL simul_clear got %h exp %h", {lap_active, disp_bcd}, 25'h0); end
    @(negedge clk_in) begin ss = 1'b1; tick_in = 1'b1; end
    @(negedge clk_in) begin ss = 1'b0; tick_in = 1'b0; end
    wait_cyc(2);
    checks++; if ({running, disp_bcd} !== 25'h1000000) begin errors++; $display("FAIL start_tick got %h exp %h", {running, disp_bcd}, 25'h1000000); end
    tick_n(2);
    @(negedge clk_in) begin ss = 1'b1; tick_in = 1'b1; end
    @(negedge clk_in) begin ss = 1'b0; tick_in = 1'b0; end
    wait_cyc(2);
    checks++; if ({running, disp_bcd} !== 25'h0000003) begin errors++; $display("FAIL stop_tick got %h exp %h", {running, disp_bcd}, 25'h0000003); end
    press_lr();
    wait_cyc(2);
  endtask
  task automatic test_wrap();
    press_ss();
    tick_n(5999);
    wait_cyc(2);
    checks++; if ({wrap, disp_bcd} !== 25'h0005999) begin errors++; $display("FAIL wrap_pre got %h exp %h", {wrap, disp_bcd}, 25'h0005999); end
    @(negedge clk_in) tick_in = 1'b1;
    @(negedge clk_in) tick_in = 1'b0;
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp %b", wrap, 1'b1); end
    @(negedge clk_in);
    checks++; if ({running, wrap, disp_bcd} !== 26'h2000000) begin errors++; $display("FAIL wrap_after got %h exp %h", {running, wrap, disp_bcd}, 26'h2000000); end
    tick_n(1);
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h000001) begin errors++; $display("FAIL wrap_continue got %h exp %h", disp_bcd, 24'h000001); end
    press_ss();
    press_lr();
    wait_cyc(2);
  endtask
  task automatic test_reset_mid();
    press_ss();
    tick_n(10);
    press_lr();
    checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL mid_lap got %b exp %b", lap_active, 1'b1); end
    @(negedge clk_in) rst = 1'b1;
    @(negedge clk_in) rst = 1'b0;
    checks++; if ({running, lap_active, wrap, disp_bcd} !== 27'h0) begin errors++; $display("FAIL mid_reset got %h exp %h", {running, lap_active, wrap, disp_bcd}, 27'h0); end
    tick_n(2);
    wait_cyc(2);
    checks++; if (disp_bcd !== 24'h0) begin errors++; $display("FAIL mid_idle got %h exp %h", disp_bcd, 24'h0); end
  endtask
  task automatic test_pulse_minutes();
    @(negedge clk_in) ss2 = 1'b1;
    @(negedge clk_in) ss2 = 1'b0;
    @(negedge clk_in) tick2 = 1'b1;
    wait_cyc(6000);
    tick2 = 1'b0;
    wait_cyc(2);
    checks++; if (disp2 !== 24'h010000) begin errors++; $display("FAIL pulse_minute got %h exp %h", disp2, 24'h010000); end
    tick2 = 1'b1;
    wait_cyc(5999);
    tick2 = 1'b0;
    wait_cyc(2);
    checks++; if ({wrap2, disp2} !== 25'h0015999) begin errors++; $display("FAIL pulse_pre got %h exp %h", {wrap2, disp2}, 25'h0015999); end
    tick2 = 1'b1;
    @(negedge clk_in) tick2 = 1'b0;
    checks++; if (wrap2 !== 1'b1) begin errors++; $display("FAIL pulse_wrap got %b exp %b", wrap2, 1'b1); end
    @(negedge clk_in);
    checks++; if ({running2, wrap2, disp2} !== 26'h2000000) begin errors++; $display("FAIL pulse_after got %h exp %h", {running2, wrap2, disp2}, 26'h2000000); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lap();
    test_simul();
    test_wrap();
    test_reset_mid();
    test_pulse_minutes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
